// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO register owner: sequences MULT/MULTU (fixed latency), DIV/DIVU (32-cycle
// restoring divider) and MTHI/MTLO, and stalls EX while a busy result is pending.
module hilo_muldiv_ctrl #(
  parameter int unsigned MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [2:0]  op_type,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [1:0]  mfhl_req,
  input  logic        flush,
  output logic        op_ready,
  output logic        stall,
  output logic        done,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  state_t      state_q, state_d;
  logic [4:0]  count_q, count_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        done_q, done_d;
  logic [63:0] prod_q, prod_d;
  logic [31:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d, a_raw_q, a_raw_d;
  logic        qneg_q, qneg_d, rneg_q, rneg_d, div0_q, div0_d;

  logic        accept;
  logic        is_signed;
  logic [63:0] a_ext, b_ext;
  logic [31:0] a_mag, b_mag;
  logic [32:0] partial, diff;
  logic        step_ok;
  logic [31:0] rem_nx, quo_nx;

  assign op_ready = (state_q == S_IDLE);
  assign stall    = (state_q != S_IDLE) & (op_valid | (|mfhl_req));
  assign accept   = op_valid & op_ready & ~flush & (op_type <= OP_MTLO);
  assign done     = done_q;
  assign hi_out   = hi_q;
  assign lo_out   = lo_q;

  // Signedness is bit 0 clear for both MULT and DIV encodings.
  assign is_signed = ~op_type[0];
  assign a_ext = is_signed ? {{32{op_a[31]}}, op_a} : {32'd0, op_a};
  assign b_ext = is_signed ? {{32{op_b[31]}}, op_b} : {32'd0, op_b};
  assign a_mag = (is_signed & op_a[31]) ? (32'd0 - op_a) : op_a;
  assign b_mag = (is_signed & op_b[31]) ? (32'd0 - op_b) : op_b;

  // One restoring step: shift the next dividend bit into the remainder, subtract if it fits.
  assign partial = {rem_q, quo_q[31]};
  assign diff    = partial - {1'b0, dvs_q};
  assign step_ok = ~diff[32];
  assign rem_nx  = step_ok ? diff[31:0] : partial[31:0];
  assign quo_nx  = {quo_q[30:0], step_ok};

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    prod_d  = prod_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    a_raw_d = a_raw_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    div0_d  = div0_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (op_type)
            OP_MULT, OP_MULTU: begin
              prod_d  = a_ext * b_ext;
              count_d = 5'(MUL_LAT - 1);
              state_d = S_MUL;
            end
            OP_DIV, OP_DIVU: begin
              rem_d   = 32'd0;
              quo_d   = a_mag;
              dvs_d   = b_mag;
              a_raw_d = op_a;
              qneg_d  = is_signed & (op_a[31] ^ op_b[31]);
              rneg_d  = is_signed & op_a[31];
              div0_d  = (op_b == 32'd0);
              count_d = 5'd31;
              state_d = S_DIV;
            end
            OP_MTHI: hi_d = op_a;
            OP_MTLO: lo_d = op_a;
            default: ;
          endcase
        end
      end
      S_MUL: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (count_q == 5'd0) begin
          hi_d    = prod_q[63:32];
          lo_d    = prod_q[31:0];
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          count_d = count_q - 5'd1;
        end
      end
      S_DIV: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          rem_d = rem_nx;
          quo_d = quo_nx;
          if (count_q == 5'd0) begin
            if (div0_q) begin
              hi_d = a_raw_q;
              lo_d = 32'hFFFF_FFFF;
            end else begin
              hi_d = rneg_q ? (32'd0 - rem_nx) : rem_nx;
              lo_d = qneg_q ? (32'd0 - quo_nx) : quo_nx;
            end
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            count_d = count_q - 5'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      count_q <= 5'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      done_q  <= 1'b0;
      prod_q  <= 64'd0;
      rem_q   <= 32'd0;
      quo_q   <= 32'd0;
      dvs_q   <= 32'd0;
      a_raw_q <= 32'd0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      prod_q  <= prod_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      a_raw_q <= a_raw_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      div0_q  <= div0_d;
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Directed bench for hilo_muldiv_ctrl: timing and results of every op type,
// stall, flush and reset behaviour against hand-computed values.
module tb_hilo_muldiv_ctrl;

  localparam int MUL_LAT = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        op_valid = 1'b0;
  logic [2:0]  op_type = 3'd0;
  logic [31:0] op_a = 32'd0;
  logic [31:0] op_b = 32'd0;
  logic [1:0]  mfhl_req = 2'b00;
  logic        flush = 1'b0;
  logic        op_ready, stall, done;
  logic [31:0] hi_out, lo_out;

  int total = 0;
  int bad = 0;

  hilo_muldiv_ctrl #(.MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_type(op_type),
    .op_a(op_a), .op_b(op_b), .mfhl_req(mfhl_req), .flush(flush),
    .op_ready(op_ready), .stall(stall), .done(done),
    .hi_out(hi_out), .lo_out(lo_out)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver: present one op for exactly one (accepting) cycle; returns in cycle T+1
  task automatic issue(input logic [2:0] t, input logic [31:0] a, input logic [31:0] b);
    op_valid = 1'b1;
    op_type  = t;
    op_a     = a;
    op_b     = b;
    tick();
    op_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    total++;
    if ({op_ready, stall, done} !== 3'b100) begin
      bad++;
      $display("FAIL reset_ctrl: got rdy/stall/done=%b want 100", {op_ready, stall, done});
    end
    total++;
    if ({hi_out, lo_out} !== 64'd0) begin
      bad++;
      $display("FAIL reset_hilo: got %h_%h want 0_0", hi_out, lo_out);
    end
  endtask

  task automatic test_mult(input logic [2:0] t, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int busy_err;
    busy_err = 0;
    issue(t, a, b);
    for (int i = 0; i < MUL_LAT; i++) begin
      if (op_ready !== 1'b0 || done !== 1'b0) busy_err++;
      tick();
    end
    total++;
    if (busy_err != 0) begin
      bad++;
      $display("FAIL mul_busy op=%0d: bad busy cycles=%0d want 0", t, busy_err);
    end
    total++;
    if ({op_ready, done} !== 2'b11) begin
      bad++;
      $display("FAIL mul_done op=%0d: got rdy/done=%b want 11", t, {op_ready, done});
    end
    total++;
    if (hi_out !== exp_hi || lo_out !== exp_lo) begin
      bad++;
      $display("FAIL mul_result op=%0d: got %h_%h want %h_%h", t, hi_out, lo_out, exp_hi, exp_lo);
    end
    tick();
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL mul_done_pulse op=%0d: got done=%b want 0", t, done);
    end
  endtask

  task automatic test_div();
    logic [2:0]  v_t [6];
    logic [31:0] v_a [6];
    logic [31:0] v_b [6];
    logic [31:0] v_hi[6];
    logic [31:0] v_lo[6];
    int busy_err;
    v_t[0] = 3'd2; v_a[0] = 32'hFFFF_FFF9; v_b[0] = 32'd2;          v_hi[0] = 32'hFFFF_FFFF; v_lo[0] = 32'hFFFF_FFFD;
    v_t[1] = 3'd3; v_a[1] = 32'd7;          v_b[1] = 32'd2;          v_hi[1] = 32'd1;         v_lo[1] = 32'd3;
    v_t[2] = 3'd2; v_a[2] = 32'h8000_0000; v_b[2] = 32'hFFFF_FFFF; v_hi[2] = 32'd0;         v_lo[2] = 32'h8000_0000;
    v_t[3] = 3'd3; v_a[3] = 32'd5;          v_b[3] = 32'd0;          v_hi[3] = 32'd5;         v_lo[3] = 32'hFFFF_FFFF;
    v_t[4] = 3'd2; v_a[4] = 32'd7;          v_b[4] = 32'hFFFF_FFFE; v_hi[4] = 32'd1;         v_lo[4] = 32'hFFFF_FFFD;
    v_t[5] = 3'd2; v_a[5] = 32'hFFFF_FFF9; v_b[5] = 32'd0;          v_hi[5] = 32'hFFFF_FFF9; v_lo[5] = 32'hFFFF_FFFF;
    for (int v = 0; v < 6; v++) begin
      busy_err = 0;
      issue(v_t[v], v_a[v], v_b[v]);
      for (int i = 0; i < 32; i++) begin
        if (op_ready !== 1'b0 || done !== 1'b0) busy_err++;
        tick();
      end
      total++;
      if (busy_err != 0) begin
        bad++;
        $display("FAIL div_busy v%0d: bad busy cycles=%0d want 0", v, busy_err);
      end
      total++;
      if ({op_ready, done} !== 2'b11) begin
        bad++;
        $display("FAIL div_done v%0d: got rdy/done=%b want 11", v, {op_ready, done});
      end
      total++;
      if (hi_out !== v_hi[v] || lo_out !== v_lo[v]) begin
        bad++;
        $display("FAIL div_result v%0d: got %h_%h want %h_%h", v, hi_out, lo_out, v_hi[v], v_lo[v]);
      end
      tick();
    end
  endtask

  task automatic test_mthi_mtlo();
    op_valid = 1'b1; op_type = 3'd4; op_a = 32'h1234_5678;
    #1;
    total++;
    if (stall !== 1'b0) begin
      bad++;
      $display("FAIL mthi_stall: got %b want 0", stall);
    end
    tick();
    op_type = 3'd5; op_a = 32'h0BAD_F00D;
    total++;
    if (hi_out !== 32'h1234_5678 || done !== 1'b0 || op_ready !== 1'b1) begin
      bad++;
      $display("FAIL mthi_write: got hi=%h done=%b rdy=%b want 12345678 0 1", hi_out, done, op_ready);
    end
    tick();
    op_valid = 1'b0;
    total++;
    if (lo_out !== 32'h0BAD_F00D || hi_out !== 32'h1234_5678 || done !== 1'b0) begin
      bad++;
      $display("FAIL mtlo_write: got %h_%h done=%b want 12345678_0badf00d 0", hi_out, lo_out, done);
    end
  endtask

  task automatic test_illegal();
    op_valid = 1'b1; op_type = 3'd6; op_a = 32'hDEAD_BEEF; op_b = 32'd1;
    tick();
    op_type = 3'd7;
    tick();
    op_valid = 1'b0;
    total++;
    if (op_ready !== 1'b1 || done !== 1'b0 || hi_out !== 32'h1234_5678 || lo_out !== 32'h0BAD_F00D) begin
      bad++;
      $display("FAIL illegal_op: got rdy=%b done=%b %h_%h want 1 0 12345678_0badf00d",
               op_ready, done, hi_out, lo_out);
    end
  endtask

  // mfhl read and a held MTLO during DIV busy: stall throughout, MTLO lands after the result
  task automatic test_back_to_back();
    int stall_err;
    stall_err = 0;
    issue(3'd3, 32'd100, 32'd7);
    mfhl_req = 2'b10;
    op_valid = 1'b1; op_type = 3'd5; op_a = 32'hCAFE_BABE; op_b = 32'd0;
    for (int i = 0; i < 32; i++) begin
      if (stall !== 1'b1) stall_err++;
      tick();
    end
    total++;
    if (stall_err != 0) begin
      bad++;
      $display("FAIL b2b_stall: cycles without stall=%0d want 0", stall_err);
    end
    total++;
    if (stall !== 1'b0 || done !== 1'b1 || hi_out !== 32'd2 || lo_out !== 32'd14) begin
      bad++;
      $display("FAIL b2b_div: got stall=%b done=%b %h_%h want 0 1 00000002_0000000e",
               stall, done, hi_out, lo_out);
    end
    tick();
    op_valid = 1'b0;
    mfhl_req = 2'b00;
    total++;
    if (lo_out !== 32'hCAFE_BABE || hi_out !== 32'd2 || op_ready !== 1'b1) begin
      bad++;
      $display("FAIL b2b_mtlo: got %h_%h rdy=%b want 00000002_cafebabe 1", hi_out, lo_out, op_ready);
    end
  endtask

  task automatic test_flush();
    int done_seen;
    done_seen = 0;
    // flush at DIV busy cycle 10
    issue(3'd3, 32'd50, 32'd3);
    for (int i = 0; i < 9; i++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    total++;
    if (op_ready !== 1'b1 || hi_out !== 32'd2 || lo_out !== 32'hCAFE_BABE) begin
      bad++;
      $display("FAIL flush_div: got rdy=%b %h_%h want 1 00000002_cafebabe", op_ready, hi_out, lo_out);
    end
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) done_seen++;
      tick();
    end
    // flush coincident with final MUL edge
    issue(3'd1, 32'd9, 32'd9);
    for (int i = 0; i < MUL_LAT - 1; i++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (done === 1'b1) done_seen++;
      tick();
    end
    total++;
    if (done_seen != 0) begin
      bad++;
      $display("FAIL flush_no_done: got done pulses=%0d want 0", done_seen);
    end
    total++;
    if (op_ready !== 1'b1 || hi_out !== 32'd2 || lo_out !== 32'hCAFE_BABE) begin
      bad++;
      $display("FAIL flush_mul: got rdy=%b %h_%h want 1 00000002_cafebabe", op_ready, hi_out, lo_out);
    end
    // flush in IDLE suppresses MTHI
    op_valid = 1'b1; op_type = 3'd4; op_a = 32'h5555_AAAA; flush = 1'b1;
    tick();
    op_valid = 1'b0; flush = 1'b0;
    tick();
    total++;
    if (hi_out !== 32'd2) begin
      bad++;
      $display("FAIL flush_idle_mthi: got hi=%h want 00000002", hi_out);
    end
  endtask

  task automatic test_reset_mid_div();
    int done_seen;
    done_seen = 0;
    issue(3'd2, 32'hFFFF_FFF9, 32'd2);
    for (int i = 0; i < 9; i++) tick();
    #2;
    reset = 1'b1;
    #1;
    total++;
    if (op_ready !== 1'b1 || hi_out !== 32'd0 || lo_out !== 32'd0 || done !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_div: got rdy=%b done=%b %h_%h want 1 0 0_0", op_ready, done, hi_out, lo_out);
    end
    tick();
    reset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1 || op_ready !== 1'b1) done_seen++;
      tick();
    end
    total++;
    if (done_seen != 0 || hi_out !== 32'd0 || lo_out !== 32'd0) begin
      bad++;
      $display("FAIL reset_after: got bad cycles=%0d %h_%h want 0 0_0", done_seen, hi_out, lo_out);
    end
  endtask

  initial begin
    test_reset();
    test_mult(3'd0, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    test_mult(3'd1, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA);
    test_mult(3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
    test_div();
    test_mthi_mtlo();
    test_illegal();
    test_back_to_back();
    test_flush();
    test_reset_mid_div();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
